// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and helpers for the register file.
// Holds default geometry and the index-width function.
package regfile_pkg;

  localparam int WIDTH_DEF    = 64;
  localparam int DEPTH_DEF    = 32;
  localparam int ZERO_REG_DEF = 31;

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_sb_register_n.sv
// register_n: WIDTH-bit register with write enable.
// Asynchronous active-low reset clears it to zero.
module register_n #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // Load d_i when enabled; async clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with zero register and busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = WIDTH_DEF,
  parameter  int DEPTH    = DEPTH_DEF,
  parameter  int ZERO_REG = ZERO_REG_DEF,
  localparam int AW       = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [AW-1:0]    WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [AW-1:0]    ReadRegister1,
  input  logic [AW-1:0]    ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2,
  input  logic             Reserve,
  input  logic [AW-1:0]    ReserveRegister,
  output logic             Busy1,
  output logic             Busy2
);

  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] wr_dec;
  logic [DEPTH-1:0] rs_dec;
  logic [DEPTH-1:0] busy_d;
  logic [DEPTH-1:0] busy_q;

  // One-hot write/reserve decode; the zero register is never targeted.
  always_comb begin
    wr_dec = '0;
    rs_dec = '0;
    if (RegWrite) wr_dec[WriteRegister] = 1'b1;
    if (Reserve) rs_dec[ReserveRegister] = 1'b1;
    wr_dec[ZERO_REG] = 1'b0;
    rs_dec[ZERO_REG] = 1'b0;
  end

  // Writeback clears busy; a same-cycle reservation wins over the clear.
  always_comb begin
    busy_d = (busy_q & ~wr_dec) | rs_dec;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_data
    register_n #(
      .WIDTH(WIDTH)
    ) u_reg (
      .clk  (clk),
      .rst_n(reset),
      .en_i (wr_dec[g]),
      .d_i  (WriteData),
      .q_o  (data_q[g])
    );
  end

  register_n #(
    .WIDTH(DEPTH)
  ) u_busy (
    .clk  (clk),
    .rst_n(reset),
    .en_i (1'b1),
    .d_i  (busy_d),
    .q_o  (busy_q)
  );

`ifdef REGFILE_BYPASS_EN
  logic fwd1;
  logic fwd2;
  logic rsv_wr;

  // Forwarding is suppressed while reset holds everything at zero.
  always_comb begin
    fwd1   = reset && RegWrite && (WriteRegister != ZR) &&
             (ReadRegister1 == WriteRegister);
    fwd2   = reset && RegWrite && (WriteRegister != ZR) &&
             (ReadRegister2 == WriteRegister);
    rsv_wr = Reserve && (ReserveRegister == WriteRegister);
  end
`endif

  // Combinational read ports; zero register reads as idle zero.
  always_comb begin
    ReadData1 = data_q[ReadRegister1];
    ReadData2 = data_q[ReadRegister2];
    Busy1     = busy_q[ReadRegister1];
    Busy2     = busy_q[ReadRegister2];
`ifdef REGFILE_BYPASS_EN
    if (fwd1) begin
      ReadData1 = WriteData;
      if (!rsv_wr) Busy1 = 1'b0;
    end
    if (fwd2) begin
      ReadData2 = WriteData;
      if (!rsv_wr) Busy2 = 1'b0;
    end
`endif
    if (ReadRegister1 == ZR) begin
      ReadData1 = '0;
      Busy1     = 1'b0;
    end
    if (ReadRegister2 == ZR) begin
      ReadData2 = '0;
      Busy2     = 1'b0;
    end
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file for the pipelined CPU datapath: DEPTH registers of WIDTH bits, two combinational read ports, one clocked write port, a hard-wired zero register and a per-register busy scoreboard for hazard detection. It replaces the fixed 32-bit storage elements in the decode stage. The ID stage reads operands and busy status here. The ID stage also reserves destinations at issue. The WB stage writes results back and clears the reservations.

## Interface
- WIDTH, 64, data width of every register
- DEPTH, 32, number of registers (power of two, ≥2)
- ZERO_REG, 31, index that always reads 0, ignores writes, never busy
- AW (localparam), $clog2(DEPTH), register-index width
- clk  in  1  rising-edge clock, sole clock of the block
- reset  in  1  asynchronous, active-low; asserting (0) clears all state immediately
- RegWrite  in  1  write enable for the WB port
- WriteRegister  in  AW  WB destination index
- WriteData  in  WIDTH  WB data
- ReadRegister1, ReadRegister2  in  AW  read indices
- ReadData1, ReadData2  out  WIDTH  read data
- Reserve  in  1  mark a destination busy (instruction issued)
- ReserveRegister  in  AW  index to mark busy
- Busy1, Busy2  out  1  busy bit of ReadRegister1/2

## Operation
- Storage: DEPTH×WIDTH flops plus DEPTH busy flops.
- Write: on rising clk with RegWrite=1 and WriteRegister≠ZERO_REG, register ← WriteData. Busy bit of that register ← 0 unless also reserved this cycle.
- Reserve: on rising clk with Reserve=1 and ReserveRegister≠ZERO_REG, busy bit ← 1.
- Same register written and reserved in one cycle: busy ends 1 (the newer reservation wins); data still updated.
- RegWrite or Reserve to ZERO_REG: no effect.
- Reads are combinational from index to ReadData and Busy.
- Reads of ZERO_REG always return ReadData=0 and Busy=0.
- Indices ≥ DEPTH cannot occur (AW exact); no range checking.
- Both read ports may address the same register; both return identical values.

## Timing
- Reset (reset=0, async): all registers 0, all busy bits 0; hence ReadData1/2=0, Busy1/2=0 for any index until the first write/reserve. Reset mid-cycle overrides any concurrent write or reserve.
- Write latency: visible on read ports the cycle after the write edge (without bypass).
- Reserve latency: Busy visible the cycle after the reserve edge.
- Read path: purely combinational, zero cycles; no output registers.
- Reset deassertion: the first rising clk after reset returns to 1 may perform a write or reserve.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle write forwarding is enabled.
  - While RegWrite=1 and ReadRegisterN=WriteRegister≠ZERO_REG, ReadDataN=WriteData and BusyN=0.
  - Exception: if that register is also being reserved this cycle, BusyN reports the stored busy bit.
- REGFILE_BYPASS_EN undefined: reads always return stored contents. The WB→ID hazard is then resolved by the pipeline stalling one cycle.

## Structure
- Package regfile_pkg holds the default values for WIDTH and DEPTH, the default ZERO_REG value, and an addr_width function wrapping $clog2.
- Sub-module register_n: parameterised WIDTH register with write enable and async active-low reset.
  - Instantiated DEPTH times for data.
  - Busy bits use one DEPTH-wide register_n with a per-bit next-state.
- Read muxes and the bypass compare live in regfile_sb.

## Test plan
- Reset with all inputs random → every index reads 0, Busy=0; release reset, no writes → still 0.
- Write 0xDEADBEEF_0000_0001 to X5. The next cycle, ReadRegister1=ReadRegister2=5 → both ports read 0xDEADBEEF_0000_0001. X6 still reads 0.
- Write 0xFFFF… to X31 (ZERO_REG), then read X31 → 0, Busy=0; Reserve X31 → Busy stays 0.
- Reserve X3 at cycle n → Busy1=1 at n+1. Write X3=7 at n+2 → Busy1=0 and ReadData1=7 at n+3. Reserve and write X3 in the same cycle → Busy1=1 and ReadData1=new data.
- With REGFILE_BYPASS_EN: read X9 while writing X9=0x42 → ReadData=0x42 and Busy=0 in the same cycle. Without the macro → ReadData shows the old value and the new value appears the next cycle.
- Assert reset mid-stream, concurrent with a write to X2 → X2 reads 0 and all Busy bits are 0 immediately, before the next clk edge.
